// File: rtl/dense_packer.sv
// dense_packer: collects NUMI_ONCE scalar elements from a valid-qualified
// stream into one wide vector and emits it with a single-cycle strobe.
// Accumulation continues while a vector sits in the output register, so a
// continuous input stream produces no bubbles.
module dense_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUMI_ONCE  = 128,
   parameter int CNT_W      = $clog2(NUMI_ONCE + 1)
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [DATA_WIDTH-1:0]            data_i,
   input  logic                             valid_i,
   input  logic                             flush_i,
   output logic [DATA_WIDTH*NUMI_ONCE-1:0]  data_o,
   output logic                             valid_o,
   output logic [CNT_W-1:0]                 len_o,
   output logic [CNT_W-1:0]                 count_o
);

   localparam int               VEC_W    = DATA_WIDTH * NUMI_ONCE;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMI_ONCE - 1);

   // accumulation side
   logic [VEC_W-1:0] r_buf;
   logic [CNT_W-1:0] r_cnt;
   // emission side (gated: zero whenever r_valid is low)
   logic [VEC_W-1:0] r_data;
   logic [CNT_W-1:0] r_len;
   logic             r_valid;

   logic [VEC_W-1:0] w_vec;
   logic [CNT_W-1:0] w_total;
   logic             w_full;
   logic             w_emit;

   // Buffer contents with the same-cycle element merged into lane r_cnt
   always_comb begin
      w_vec = r_buf;
      for (int k = 0; k < NUMI_ONCE; k++) begin
         if (valid_i && (r_cnt == CNT_W'(k))) begin
            w_vec[k*DATA_WIDTH +: DATA_WIDTH] = data_i;
         end else begin
            w_vec[k*DATA_WIDTH +: DATA_WIDTH] = r_buf[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Emission decision: vector filled by this element, or a flush with something to send
   always_comb begin
      w_total = r_cnt + {{(CNT_W-1){1'b0}}, valid_i};
      w_full  = 1'b0;
      w_emit  = 1'b0;
      if (valid_i && (r_cnt == LAST_IDX)) begin
         w_full = 1'b1;
      end else begin
         w_full = 1'b0;
      end
      if (w_full || (flush_i && (w_total != {CNT_W{1'b0}}))) begin
         w_emit = 1'b1;
      end else begin
         w_emit = 1'b0;
      end
   end

   // Accumulation buffer and write pointer; cleared whenever a vector leaves
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_buf <= {VEC_W{1'b0}};
         r_cnt <= {CNT_W{1'b0}};
      end else if (w_emit) begin
         r_buf <= {VEC_W{1'b0}};
         r_cnt <= {CNT_W{1'b0}};
      end else if (valid_i) begin
         r_buf <= w_vec;
         r_cnt <= r_cnt + {{(CNT_W-1){1'b1 ^ 1'b1}}, 1'b1};
      end else begin
         r_buf <= r_buf;
         r_cnt <= r_cnt;
      end
   end

   // Output register: one-cycle pulse carrying the vector, zero otherwise
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_data  <= {VEC_W{1'b0}};
         r_len   <= {CNT_W{1'b0}};
      end else if (w_emit) begin
         r_valid <= 1'b1;
         r_data  <= w_vec;
         r_len   <= w_total;
      end else begin
         r_valid <= 1'b0;
         r_data  <= {VEC_W{1'b0}};
         r_len   <= {CNT_W{1'b0}};
      end
   end

   assign data_o  = r_data;
   assign valid_o = r_valid;
   assign len_o   = r_len;
   assign count_o = r_cnt;

endmodule

// File: tb/tb_dense_packer.sv
// Directed self-checking bench for dense_packer (DATA_WIDTH=8, NUMI_ONCE=128).
module tb_dense_packer;

   localparam int DW    = 8;
   localparam int N     = 128;
   localparam int CW    = $clog2(N + 1);
   localparam int VEC_W = DW * N;

   logic              clk;
   logic              rstn;
   logic [DW-1:0]     data_i;
   logic              valid_i;
   logic              flush_i;
   logic [VEC_W-1:0]  data_o;
   logic              valid_o;
   logic [CW-1:0]     len_o;
   logic [CW-1:0]     count_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [VEC_W-1:0] exp_a;
   logic [VEC_W-1:0] exp_b;
   int p1;
   int p2;

   dense_packer #(.DATA_WIDTH(DW), .NUMI_ONCE(N)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .data_i  (data_i),
      .valid_i (valid_i),
      .flush_i (flush_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .len_o   (len_o),
      .count_o (count_o)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one edge and settle so outputs reflect that edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // apply one cycle of inputs and clock it in
   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic f);
      valid_i = v;
      data_i  = d;
      flush_i = f;
      tick();
   endtask

   task automatic chk_s(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_v(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   initial begin
      rstn = 1'b0; valid_i = 1'b0; data_i = 8'h00; flush_i = 1'b0;
      tick(); tick();
      chk_s("rst_valid", 32'(valid_o), 32'd0);
      chk_v("rst_data", data_o, '0);
      chk_s("rst_len", 32'(len_o), 32'd0);
      chk_s("rst_count", 32'(count_o), 32'd0);
      rstn = 1'b1;

      // full vector
      exp_a = '0;
      for (int j = 0; j < N; j++) begin
         exp_a[j*DW +: DW] = 8'(j);
         cyc(1'b1, 8'(j), 1'b0);
         if (j < N - 1) begin
            chk_s("full_nopulse", 32'(valid_o), 32'd0);
            chk_s("full_count", 32'(count_o), 32'(j + 1));
         end
      end
      chk_s("full_valid", 32'(valid_o), 32'd1);
      chk_v("full_data", data_o, exp_a);
      chk_s("full_len", 32'(len_o), 32'd128);
      chk_s("full_count0", 32'(count_o), 32'd0);
      cyc(1'b0, 8'h00, 1'b0);
      chk_s("full_after_valid", 32'(valid_o), 32'd0);
      chk_v("full_after_data", data_o, '0);
      chk_s("full_after_len", 32'(len_o), 32'd0);

      // back-to-back 256 elements
      exp_b = '0;
      for (int j = 0; j < N; j++) exp_b[j*DW +: DW] = 8'(N + j);
      p1 = -1; p2 = -1;
      for (int j = 0; j < 2 * N; j++) begin
         cyc(1'b1, 8'(j), 1'b0);
         if (valid_o === 1'b1 && p1 < 0) p1 = j;
         else if (valid_o === 1'b1) p2 = j;
         if (j == N - 1) begin
            chk_s("b2b_p1_valid", 32'(valid_o), 32'd1);
            chk_v("b2b_p1_data", data_o, exp_a);
         end else if (j == 2 * N - 1) begin
            chk_s("b2b_p2_valid", 32'(valid_o), 32'd1);
            chk_v("b2b_p2_data", data_o, exp_b);
            chk_s("b2b_p2_len", 32'(len_o), 32'd128);
         end else begin
            chk_s("b2b_nopulse", 32'(valid_o), 32'd0);
         end
      end
      chk_s("b2b_gap", 32'(p2 - p1), 32'd128);
      cyc(1'b0, 8'h00, 1'b0);

      // gapped input, one element every third cycle
      exp_a = '0;
      for (int j = 0; j < N; j++) begin
         exp_a[j*DW +: DW] = 8'h2F + 8'(j >> 1);
         cyc(1'b0, 8'h00, 1'b0);
         cyc(1'b0, 8'h00, 1'b0);
         chk_s("gap_count_hold", 32'(count_o), 32'(j));
         cyc(1'b1, 8'h2F + 8'(j >> 1), 1'b0);
         if (j < N - 1) begin
            chk_s("gap_nopulse", 32'(valid_o), 32'd0);
            chk_s("gap_count", 32'(count_o), 32'(j + 1));
         end
      end
      chk_s("gap_valid", 32'(valid_o), 32'd1);
      chk_v("gap_data", data_o, exp_a);
      chk_s("gap_len", 32'(len_o), 32'd128);
      cyc(1'b0, 8'h00, 1'b0);
      chk_s("gap_after_valid", 32'(valid_o), 32'd0);

      // flush of a 5-element partial vector
      exp_a = '0;
      for (int i = 0; i < 5; i++) begin
         exp_a[i*DW +: DW] = 8'hA1 + 8'(i);
         cyc(1'b1, 8'hA1 + 8'(i), 1'b0);
      end
      chk_s("fl5_count", 32'(count_o), 32'd5);
      cyc(1'b0, 8'h00, 1'b1);
      chk_s("fl5_valid", 32'(valid_o), 32'd1);
      chk_v("fl5_data", data_o, exp_a);
      chk_s("fl5_len", 32'(len_o), 32'd5);
      chk_s("fl5_count0", 32'(count_o), 32'd0);

      // flush with nothing held
      cyc(1'b0, 8'h00, 1'b1);
      chk_s("fl0_valid", 32'(valid_o), 32'd0);
      chk_s("fl0_len", 32'(len_o), 32'd0);

      // flush that includes the same-cycle element, then a 1-element flush right after
      cyc(1'b1, 8'h11, 1'b0);
      cyc(1'b1, 8'h22, 1'b0);
      cyc(1'b1, 8'h33, 1'b1);
      exp_a = '0;
      exp_a[23:0] = 24'h332211;
      chk_s("fl3_valid", 32'(valid_o), 32'd1);
      chk_v("fl3_data", data_o, exp_a);
      chk_s("fl3_len", 32'(len_o), 32'd3);
      cyc(1'b1, 8'h44, 1'b1);
      exp_a = '0;
      exp_a[7:0] = 8'h44;
      chk_s("fl1_valid", 32'(valid_o), 32'd1);
      chk_v("fl1_data", data_o, exp_a);
      chk_s("fl1_len", 32'(len_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b0);
      chk_s("fl1_after_valid", 32'(valid_o), 32'd0);

      // flush coinciding with the 128th element
      exp_a = '0;
      for (int j = 0; j < N; j++) begin
         exp_a[j*DW +: DW] = 8'(j + 7);
         cyc(1'b1, 8'(j + 7), (j == N - 1) ? 1'b1 : 1'b0);
      end
      chk_s("flfull_valid", 32'(valid_o), 32'd1);
      chk_v("flfull_data", data_o, exp_a);
      chk_s("flfull_len", 32'(len_o), 32'd128);
      cyc(1'b0, 8'h00, 1'b0);
      chk_s("flfull_single", 32'(valid_o), 32'd0);
      chk_s("flfull_count", 32'(count_o), 32'd0);

      // reset mid-vector discards partial data
      for (int j = 0; j < 60; j++) cyc(1'b1, 8'hFF, 1'b0);
      rstn = 1'b0;
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      chk_s("rmid_count", 32'(count_o), 32'd0);
      chk_s("rmid_valid", 32'(valid_o), 32'd0);
      rstn = 1'b1;
      exp_a = '0;
      for (int j = 0; j < N; j++) begin
         exp_a[j*DW +: DW] = 8'h02 + 8'(j >> 1);
         cyc(1'b1, 8'h02 + 8'(j >> 1), 1'b0);
         if (j < N - 1) chk_s("rmid_nopulse", 32'(valid_o), 32'd0);
      end
      chk_s("rmid_pvalid", 32'(valid_o), 32'd1);
      chk_v("rmid_data", data_o, exp_a);
      chk_s("rmid_len", 32'(len_o), 32'd128);

      // reset on the edge that would fill the vector cancels the pulse
      for (int j = 0; j < N - 1; j++) cyc(1'b1, 8'h5A, 1'b0);
      rstn = 1'b0;
      cyc(1'b1, 8'h5A, 1'b0);
      chk_s("rcan_valid", 32'(valid_o), 32'd0);
      chk_v("rcan_data", data_o, '0);
      chk_s("rcan_count", 32'(count_o), 32'd0);
      rstn = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      chk_s("rcan_after_valid", 32'(valid_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
